// File: rtl/phy_link_monitor.sv
// phy_link_monitor: polls an MII PHY through the MAC's MDIO register window and
// resolves link state, speed and duplex from BMSR, ANAR and ANLPAR.
module phy_link_monitor #(
    parameter int unsigned POLL_CYCLES    = 500000,
    parameter int unsigned PHY_ADDR       = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        enable,
    output logic [7:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        link_up,
    output logic        full_duplex,
    output logic        set_10,
    output logic        set_1000,
    output logic        link_change,
    output logic        bus_error,
    output logic        busy
);

    localparam int POLL_W  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [7:0] ADDR_MDIO_CFG = 8'h3F;
    localparam logic [7:0] ADDR_BMSR     = 8'h81;
    localparam logic [7:0] ADDR_ANAR     = 8'h84;
    localparam logic [7:0] ADDR_ANLPAR   = 8'h85;

    typedef enum logic [2:0] {
        IDLE,
        CFG_WR,
        RD_BMSR,
        RD_ANAR,
        RD_ANLPAR,
        RESOLVE,
        WAIT_POLL
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          avm_address_q, avm_address_d;
    logic                avm_read_q, avm_read_d;
    logic                avm_write_q, avm_write_d;
    logic [31:0]         avm_writedata_q, avm_writedata_d;
    logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [3:0]          anar_q, anar_d;
    logic                link_up_q, link_up_d;
    logic                set_10_q, set_10_d;
    logic                full_duplex_q, full_duplex_d;
    logic                change_pend_q, change_pend_d;
    logic                link_change_q, link_change_d;
    logic                bus_error_q, bus_error_d;
    logic                busy_q, busy_d;

    logic                strobe;
    logic [3:0]          caps;
    logic                res_set_10;
    logic                res_full_duplex;
    logic                unused_rdata;

    assign strobe       = avm_read_q | avm_write_q;
    assign unused_rdata = ^{avm_readdata[31:9], avm_readdata[4:3], avm_readdata[1:0]};

    function automatic logic [7:0] access_addr(input state_e s);
        case (s)
            CFG_WR:    access_addr = ADDR_MDIO_CFG;
            RD_BMSR:   access_addr = ADDR_BMSR;
            RD_ANAR:   access_addr = ADDR_ANAR;
            default:   access_addr = ADDR_ANLPAR;
        endcase
    endfunction

    // Highest common ability wins; no common ability falls back to 10 Mb/s half duplex.
    always_comb begin
        caps = anar_q & avm_readdata[8:5];
        if (caps[3]) begin
            res_set_10      = 1'b0;
            res_full_duplex = 1'b1;
        end else if (caps[2]) begin
            res_set_10      = 1'b0;
            res_full_duplex = 1'b0;
        end else if (caps[1]) begin
            res_set_10      = 1'b1;
            res_full_duplex = 1'b1;
        end else begin
            res_set_10      = 1'b1;
            res_full_duplex = 1'b0;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d         = state_q;
        avm_address_d   = avm_address_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        avm_writedata_d = avm_writedata_q;
        poll_cnt_d      = poll_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        anar_d          = anar_q;
        link_up_d       = link_up_q;
        set_10_d        = set_10_q;
        full_duplex_d   = full_duplex_q;
        change_pend_d   = change_pend_q;
        link_change_d   = 1'b0;
        bus_error_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) state_d = CFG_WR;
            end

            CFG_WR, RD_BMSR, RD_ANAR, RD_ANLPAR: begin
                if (!strobe) begin
                    // Entry cycle of each access doubles as the mandatory idle bus cycle.
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        avm_address_d = access_addr(state_q);
                        if (state_q == CFG_WR) begin
                            avm_write_d     = 1'b1;
                            avm_writedata_d = {27'b0, 5'(PHY_ADDR)};
                        end else begin
                            avm_read_d = 1'b1;
                        end
                    end
                end else if (avm_waitrequest) begin
                    if (stall_cnt_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                        avm_read_d  = 1'b0;
                        avm_write_d = 1'b0;
                        stall_cnt_d = '0;
                        bus_error_d = 1'b1;
                        poll_cnt_d  = POLL_W'(POLL_CYCLES - 1);
                        state_d     = enable ? WAIT_POLL : IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + 1'b1;
                    end
                end else begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    stall_cnt_d = '0;
                    if (!enable) begin
                        state_d = IDLE;
                    end else begin
                        case (state_q)
                            CFG_WR: state_d = RD_BMSR;
                            RD_BMSR: begin
                                if (avm_readdata[2]) begin
                                    state_d = RD_ANAR;
                                end else begin
                                    state_d       = RESOLVE;
                                    link_up_d     = 1'b0;
                                    change_pend_d = link_up_q;
                                end
                            end
                            RD_ANAR: begin
                                anar_d  = avm_readdata[8:5];
                                state_d = RD_ANLPAR;
                            end
                            RD_ANLPAR: begin
                                state_d       = RESOLVE;
                                link_up_d     = 1'b1;
                                set_10_d      = res_set_10;
                                full_duplex_d = res_full_duplex;
                                change_pend_d = !link_up_q
                                             || (res_set_10 != set_10_q)
                                             || (res_full_duplex != full_duplex_q);
                            end
                            default: ;
                        endcase
                    end
                end
            end

            RESOLVE: begin
                link_change_d = change_pend_q;
                change_pend_d = 1'b0;
                poll_cnt_d    = POLL_W'(POLL_CYCLES - 1);
                state_d       = WAIT_POLL;
            end

            WAIT_POLL: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (poll_cnt_q == '0) begin
                    state_d = RD_BMSR;
                end else begin
                    poll_cnt_d = poll_cnt_q - 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != WAIT_POLL);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q         <= IDLE;
            avm_address_q   <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            avm_writedata_q <= '0;
            poll_cnt_q      <= '0;
            stall_cnt_q     <= '0;
            anar_q          <= '0;
            link_up_q       <= 1'b0;
            set_10_q        <= 1'b1;
            full_duplex_q   <= 1'b0;
            change_pend_q   <= 1'b0;
            link_change_q   <= 1'b0;
            bus_error_q     <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            avm_address_q   <= avm_address_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            avm_writedata_q <= avm_writedata_d;
            poll_cnt_q      <= poll_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            anar_q          <= anar_d;
            link_up_q       <= link_up_d;
            set_10_q        <= set_10_d;
            full_duplex_q   <= full_duplex_d;
            change_pend_q   <= change_pend_d;
            link_change_q   <= link_change_d;
            bus_error_q     <= bus_error_d;
            busy_q          <= busy_d;
        end
    end

    assign avm_address   = avm_address_q;
    assign avm_read      = avm_read_q;
    assign avm_write     = avm_write_q;
    assign avm_writedata = avm_writedata_q;
    assign link_up       = link_up_q;
    assign set_10        = set_10_q;
    assign set_1000      = 1'b0;
    assign full_duplex   = full_duplex_q;
    assign link_change   = link_change_q;
    assign bus_error     = bus_error_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_phy_link_monitor.sv
// tb_phy_link_monitor: bus responder plus scoreboard of expected MAC accesses
// for phy_link_monitor, with per-round checks of the resolved link state.
module tb_phy_link_monitor;

    localparam int unsigned POLL    = 16;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned PHY     = 9;

    logic        clk_clk;
    logic        reset_reset_n;
    logic        enable;
    logic [7:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        link_up;
    logic        full_duplex;
    logic        set_10;
    logic        set_1000;
    logic        link_change;
    logic        bus_error;
    logic        busy;

    phy_link_monitor #(
        .POLL_CYCLES    (POLL),
        .PHY_ADDR       (PHY),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .link_up         (link_up),
        .full_duplex     (full_duplex),
        .set_10          (set_10),
        .set_1000        (set_1000),
        .link_change     (link_change),
        .bus_error       (bus_error),
        .busy            (busy)
    );

    initial begin
        clk_clk = 1'b0;
        forever #5 clk_clk = ~clk_clk;
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        timeout;
    } bus_op_t;

    bus_op_t     exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] bmsr_val, anar_val, anlpar_val;
    int          wait_cycles;
    logic [7:0]  stall_addr;

    int          cyc = 0;
    int          lc_count, be_count;
    int          last_lc_cycle, rise_after_lc;
    bit          rise_pending, in_acc, gap_pend, both_seen, addr_moved;
    logic [7:0]  acc_addr;
    logic        acc_wr;
    logic [31:0] acc_data;
    int          acc_len, stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_op(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                           input logic timeout);
        bus_op_t op;
        op.wr      = wr;
        op.addr    = addr;
        op.data    = data;
        op.timeout = timeout;
        exp_q.push_back(op);
    endtask

    task automatic push_round(input logic with_cfg);
        if (with_cfg) push_op(1'b1, 8'h3F, 32'(PHY), 1'b0);
        push_op(1'b0, 8'h81, 32'd0, 1'b0);
        push_op(1'b0, 8'h84, 32'd0, 1'b0);
        push_op(1'b0, 8'h85, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] reg_value(input logic [7:0] addr);
        case (addr)
            8'h81:   reg_value = bmsr_val;
            8'h84:   reg_value = anar_val;
            8'h85:   reg_value = anlpar_val;
            default: reg_value = 32'd0;
        endcase
    endfunction

    task automatic finish_access(input logic timed_out);
        bus_op_t e;
        if (exp_q.size() == 0) begin
            check("spurious_access", {23'd0, acc_wr, acc_addr}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("acc_addr", 32'(acc_addr), 32'(e.addr));
            check("acc_dir", 32'(acc_wr), 32'(e.wr));
            if (e.wr) check("acc_wdata", acc_data, e.data);
            check("acc_timeout", 32'(timed_out), 32'(e.timeout));
            if (timed_out) check("stall_len", 32'(acc_len), 32'(TIMEOUT));
            check("addr_stable", 32'(addr_moved), 32'd0);
        end
        in_acc = 1'b0;
    endtask

    // Responder and monitor share one process so waitrequest and the access log agree.
    always @(negedge clk_clk) begin
        logic strobe;
        cyc++;
        if (!reset_reset_n) begin
            in_acc          = 1'b0;
            gap_pend        = 1'b0;
            stall_cnt       = 0;
            avm_waitrequest = 1'b0;
            avm_readdata    = 32'd0;
        end else begin
            strobe = avm_read | avm_write;
            if (avm_read && avm_write) both_seen = 1'b1;
            if (link_change) begin
                lc_count++;
                last_lc_cycle = cyc;
                rise_pending  = 1'b1;
            end
            if (bus_error) be_count++;
            if (gap_pend) begin
                check("idle_gap", 32'(strobe), 32'd0);
                gap_pend = 1'b0;
            end
            if (strobe) begin
                if (!in_acc) begin
                    in_acc     = 1'b1;
                    acc_addr   = avm_address;
                    acc_wr     = avm_write;
                    acc_data   = avm_writedata;
                    acc_len    = 0;
                    addr_moved = 1'b0;
                    stall_cnt  = 0;
                    if (rise_pending) begin
                        rise_after_lc = cyc;
                        rise_pending  = 1'b0;
                    end
                end else if (avm_address != acc_addr || avm_write != acc_wr ||
                             avm_writedata != acc_data) begin
                    addr_moved = 1'b1;
                end
                acc_len++;
                if (avm_address == stall_addr || stall_cnt < wait_cycles) begin
                    avm_waitrequest = 1'b1;
                    avm_readdata    = $urandom();
                    stall_cnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                    avm_readdata    = reg_value(avm_address);
                    finish_access(1'b0);
                    gap_pend = 1'b1;
                end
            end else begin
                avm_waitrequest = 1'b0;
                if (in_acc) finish_access(1'b1);
            end
        end
    end

    task automatic wait_busy(input string tag, input logic level, input int limit);
        int n = 0;
        while (busy !== level && n < limit) begin
            @(negedge clk_clk);
            n++;
        end
        check({tag, "_busy_wait"}, 32'(busy === level), 32'd1);
    endtask

    task automatic wait_read(input string tag, input int limit);
        int n = 0;
        while (avm_read !== 1'b1 && n < limit) begin
            @(negedge clk_clk);
            n++;
        end
        check({tag, "_read_wait"}, 32'(avm_read === 1'b1), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_link_up"},     32'(link_up),       32'd0);
        check({tag, "_set_10"},      32'(set_10),        32'd1);
        check({tag, "_set_1000"},    32'(set_1000),      32'd0);
        check({tag, "_full_duplex"}, 32'(full_duplex),   32'd0);
        check({tag, "_link_change"}, 32'(link_change),   32'd0);
        check({tag, "_bus_error"},   32'(bus_error),     32'd0);
        check({tag, "_busy"},        32'(busy),          32'd0);
        check({tag, "_strobes"},     {30'd0, avm_read, avm_write}, 32'd0);
        check({tag, "_address"},     32'(avm_address),   32'd0);
        check({tag, "_writedata"},   avm_writedata,      32'd0);
    endtask

    task automatic check_link(input string tag, input logic up, input logic s10, input logic fd);
        check({tag, "_link_up"},     32'(link_up),     32'(up));
        check({tag, "_set_10"},      32'(set_10),      32'(s10));
        check({tag, "_full_duplex"}, 32'(full_duplex), 32'(fd));
    endtask

    task automatic run_round(input string tag, input logic up, input logic s10, input logic fd,
                             input int exp_lc, input int exp_be);
        lc_count = 0;
        be_count = 0;
        enable   = 1'b1;
        wait_busy(tag, 1'b1, POLL + 20);
        wait_busy(tag, 1'b0, 200);
        repeat (2) @(negedge clk_clk);
        check_link(tag, up, s10, fd);
        check({tag, "_link_change_pulses"}, 32'(lc_count), 32'(exp_lc));
        check({tag, "_bus_error_pulses"},   32'(be_count), 32'(exp_be));
        check({tag, "_ops_pending"},        32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lc_b;
        reset_reset_n = 1'b0;
        enable        = 1'b0;
        wait_cycles   = 0;
        stall_addr    = 8'hFF;
        bmsr_val      = 32'h0;
        anar_val      = 32'h0;
        anlpar_val    = 32'h0;
        lc_count      = 0;
        be_count      = 0;
        repeat (3) @(negedge clk_clk);
        check_reset_state("por");
        reset_reset_n = 1'b1;
        repeat (3) @(negedge clk_clk);
        check("release_no_pulse", 32'(lc_count + be_count), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // 100 Mb/s full duplex from an enabled start
        bmsr_val = 32'h0004; anar_val = 32'h01E1; anlpar_val = 32'h0181;
        push_round(1'b1);
        run_round("round_100fd", 1'b1, 1'b0, 1'b1, 1, 0);

        // link lost: BMSR only, speed/duplex held
        bmsr_val = 32'h0000;
        push_op(1'b0, 8'h81, 32'd0, 1'b0);
        run_round("round_down", 1'b0, 1'b0, 1'b1, 1, 0);
        lc_b = last_lc_cycle;

        // 10 Mb/s half duplex, then an identical round with no change
        bmsr_val = 32'h0004; anar_val = 32'h0061; anlpar_val = 32'h0021;
        push_round(1'b0);
        run_round("round_10hd", 1'b1, 1'b1, 1'b0, 1, 0);
        check("poll_interval", 32'(rise_after_lc - lc_b), 32'(POLL + 1));
        push_round(1'b0);
        run_round("round_repeat", 1'b1, 1'b1, 1'b0, 0, 0);

        // ANAR read never accepted: abandon the round
        stall_addr = 8'h84;
        push_op(1'b0, 8'h81, 32'd0, 1'b0);
        push_op(1'b0, 8'h84, 32'd0, 1'b1);
        run_round("round_timeout", 1'b1, 1'b1, 1'b0, 0, 1);
        stall_addr = 8'hFF;

        // polling resumes; 10 Mb/s full duplex
        anlpar_val = 32'h0041;
        push_round(1'b0);
        run_round("round_10fd", 1'b1, 1'b1, 1'b1, 1, 0);

        // enable falls during a stalled BMSR read
        wait_cycles = 5;
        lc_count = 0;
        be_count = 0;
        push_op(1'b0, 8'h81, 32'd0, 1'b0);
        wait_read("stall_disable", POLL + 20);
        repeat (2) @(negedge clk_clk);
        enable = 1'b0;
        wait_busy("stall_disable", 1'b0, 40);
        repeat (3) @(negedge clk_clk);
        check("stall_disable_busy", 32'(busy), 32'd0);
        check("stall_disable_read", 32'(avm_read), 32'd0);
        check("stall_disable_ops_pending", 32'(exp_q.size()), 32'd0);
        check("stall_disable_pulses", 32'(lc_count + be_count), 32'd0);
        check_link("stall_disable", 1'b1, 1'b1, 1'b1);

        // reset asserted in the middle of a read
        wait_cycles = 3;
        bmsr_val = 32'h0004; anar_val = 32'h01E1; anlpar_val = 32'h01E1;
        push_op(1'b1, 8'h3F, 32'(PHY), 1'b0);
        push_op(1'b0, 8'h81, 32'd0, 1'b0);
        enable = 1'b1;
        wait_read("mid_read_reset", 40);
        @(negedge clk_clk);
        #2 reset_reset_n = 1'b0;
        #1 check("reset_drops_read", 32'(avm_read), 32'd0);
        check_reset_state("mid_read_reset");
        exp_q.delete();
        enable = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        lc_count = 0;
        be_count = 0;
        repeat (3) @(negedge clk_clk);
        check("rerelease_no_pulse", 32'(lc_count + be_count), 32'd0);
        check("rerelease_busy", 32'(busy), 32'd0);
        wait_cycles = 0;
        push_round(1'b1);
        run_round("round_after_reset", 1'b1, 1'b0, 1'b1, 1, 0);

        check("never_both_strobes", 32'(both_seen), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
